// File: rtl/logic_fu_pkg.sv
// Shared definitions for the pipelined logic functional unit: op-code encoding and widths.
package logic_fu_pkg;

  localparam int unsigned LF_OP_W = 3;

  typedef logic [LF_OP_W-1:0] lf_op_t;

  localparam lf_op_t LF_AND   = 3'd0;
  localparam lf_op_t LF_OR    = 3'd1;
  localparam lf_op_t LF_XOR   = 3'd2;
  localparam lf_op_t LF_NOR   = 3'd3;
  localparam lf_op_t LF_NAND  = 3'd4;
  localparam lf_op_t LF_XNOR  = 3'd5;
  localparam lf_op_t LF_ANDN  = 3'd6;
  localparam lf_op_t LF_PASSA = 3'd7;

endpackage

// File: rtl/logic_fu_pipe_if.sv
// Issue-side and CDB-side valid/ready handshakes of the logic functional unit.
interface logic_fu_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic [logic_fu_pkg::LF_OP_W-1:0] in_op;
  logic [WIDTH-1:0]              in_a;
  logic [WIDTH-1:0]              in_b;
  logic [TAG_W-1:0]              in_tag;

  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
  logic [TAG_W-1:0]              out_tag;
  logic                          out_zero;

  // The unit itself.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );

  // Whoever issues ops and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

endinterface

// File: rtl/logic_fu_stage.sv
// One elastic pipeline slice holding a result, its tag and its zero flag.
module logic_fu_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [TAG_W-1:0] up_tag_i,
  input  logic             up_zero_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o,
  output logic [TAG_W-1:0] dn_tag_o,
  output logic             dn_zero_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             zero_d, zero_q;

  // Empty or draining this cycle: the slot can take a new entry.
  assign up_ready_o = ~valid_q | dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    zero_d  = zero_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
        tag_d  = up_tag_i;
        zero_d = up_zero_i;
      end
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      zero_q  <= zero_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_tag_o   = tag_q;
  assign dn_zero_o  = zero_q;

endmodule

// File: rtl/logic_fu_pipe.sv
// Pipelined bitwise functional unit: op mux and zero detect feed a chain of elastic slices
// whose last slot drives the CDB-side handshake.
module logic_fu_pipe
  import logic_fu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  logic_fu_pipe_if.slave bus,
  output logic [2:0]  occupancy
);

  logic [WIDTH-1:0]  op_res;
  logic              op_zero;
  logic [STAGES-1:0] vld;

  always_comb begin
    op_res = '0;
    unique case (bus.in_op)
      LF_AND:   op_res = bus.in_a & bus.in_b;
      LF_OR:    op_res = bus.in_a | bus.in_b;
      LF_XOR:   op_res = bus.in_a ^ bus.in_b;
      LF_NOR:   op_res = ~(bus.in_a | bus.in_b);
      LF_NAND:  op_res = ~(bus.in_a & bus.in_b);
      LF_XNOR:  op_res = ~(bus.in_a ^ bus.in_b);
      LF_ANDN:  op_res = bus.in_a & ~bus.in_b;
      LF_PASSA: op_res = bus.in_a;
      default:  op_res = '0;
    endcase
  end

  assign op_zero = (op_res == '0);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid, up_ready, up_zero;
    logic             dn_valid, dn_ready, dn_zero;
    logic [WIDTH-1:0] up_data, dn_data;
    logic [TAG_W-1:0] up_tag, dn_tag;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = op_res;
      assign up_tag   = bus.in_tag;
      assign up_zero  = op_zero;
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
      assign up_tag   = g_stage[k-1].dn_tag;
      assign up_zero  = g_stage[k-1].dn_zero;
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_ready = bus.out_ready;
    end else begin : g_next
      assign dn_ready = g_stage[k+1].up_ready;
    end

    assign vld[k] = dn_valid;

    logic_fu_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .up_valid_i (up_valid),
      .up_ready_o (up_ready),
      .up_data_i  (up_data),
      .up_tag_i   (up_tag),
      .up_zero_i  (up_zero),
      .dn_valid_o (dn_valid),
      .dn_ready_i (dn_ready),
      .dn_data_o  (dn_data),
      .dn_tag_o   (dn_tag),
      .dn_zero_o  (dn_zero)
    );
  end

  // A flush squashes both handshakes in the same cycle it is raised.
  assign bus.in_ready  = ~flush & g_stage[0].up_ready;
  assign bus.out_valid = ~flush & g_stage[STAGES-1].dn_valid;
  assign bus.out_data  = g_stage[STAGES-1].dn_data;
  assign bus.out_tag   = g_stage[STAGES-1].dn_tag;
  assign bus.out_zero  = g_stage[STAGES-1].dn_zero;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + {2'b00, vld[k]};
    end
  end

endmodule

// File: tb/tb_logic_fu_pipe.sv
// Directed and randomised checks of logic_fu_pipe at STAGES = 1, 2 and 4.
module tb_logic_fu_pipe;
  import logic_fu_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] occ1, occ2, occ4;

  int n_chk;
  int n_fail;

  logic_fu_pipe_if #(.WIDTH(32), .TAG_W(4)) if1 ();
  logic_fu_pipe_if #(.WIDTH(32), .TAG_W(4)) if2 ();
  logic_fu_pipe_if #(.WIDTH(32), .TAG_W(4)) if4 ();

  logic_fu_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if1), .occupancy(occ1)
  );
  logic_fu_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if2), .occupancy(occ2)
  );
  logic_fu_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(if4), .occupancy(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
    logic        zero;
  } vec_t;

  typedef struct {
    logic        ov;
    logic [31:0] od;
    logic [3:0]  ot;
    logic        oz;
    logic        ir;
    logic [2:0]  occ;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        zero;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input logic ordy);
    case (s)
      1: begin
        if1.in_valid = v; if1.in_op = op; if1.in_a = a; if1.in_b = b;
        if1.in_tag = tag; if1.out_ready = ordy;
      end
      2: begin
        if2.in_valid = v; if2.in_op = op; if2.in_a = a; if2.in_b = b;
        if2.in_tag = tag; if2.out_ready = ordy;
      end
      default: begin
        if4.in_valid = v; if4.in_op = op; if4.in_a = a; if4.in_b = b;
        if4.in_tag = tag; if4.out_ready = ordy;
      end
    endcase
  endtask

  task automatic idle(input int s, input logic ordy);
    set_in(s, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, ordy);
  endtask

  function automatic obs_t get_obs(input int s);
    obs_t o;
    case (s)
      1: begin
        o.ov = if1.out_valid; o.od = if1.out_data; o.ot = if1.out_tag;
        o.oz = if1.out_zero; o.ir = if1.in_ready; o.occ = occ1;
      end
      2: begin
        o.ov = if2.out_valid; o.od = if2.out_data; o.ot = if2.out_tag;
        o.oz = if2.out_zero; o.ir = if2.in_ready; o.occ = occ2;
      end
      default: begin
        o.ov = if4.out_valid; o.od = if4.out_data; o.ot = if4.out_tag;
        o.oz = if4.out_zero; o.ir = if4.in_ready; o.occ = occ4;
      end
    endcase
    return o;
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] bpa(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  task automatic lat_test(input int s);
    obs_t o;
    int   lat;
    set_in(s, 1'b1, LF_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 1'b1);
    #1;
    o = get_obs(s);
    chk($sformatf("lat_in_ready_s%0d", s), 32'(o.ir), 32'd1);
    tick();
    idle(s, 1'b1);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      o = get_obs(s);
      if (o.ov) begin
        lat = c;
        break;
      end
      tick();
    end
    chk($sformatf("latency_s%0d", s), 32'(lat), 32'(s));
    chk($sformatf("zero_data_s%0d", s), o.od, 32'd0);
    chk($sformatf("zero_flag_s%0d", s), 32'(o.oz), 32'd1);
    chk($sformatf("zero_tag_s%0d", s), 32'(o.ot), 32'h3);
    tick();
    #1;
    o = get_obs(s);
    chk($sformatf("lat_drained_s%0d", s), 32'(o.occ), 32'd0);
  endtask

  initial begin
    obs_t o;
    int   in_i;
    int   out_i;
    logic ordy;
    int   sels[3];
    n_chk  = 0;
    n_fail = 0;
    sels   = '{1, 2, 4};

    vecs[0] = '{LF_AND,   32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'h00F0_000F, 1'b0};
    vecs[1] = '{LF_OR,    32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hFFF0_0FFF, 1'b0};
    vecs[2] = '{LF_XOR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hFF00_0FF0, 1'b0};
    vecs[3] = '{LF_NOR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'h000F_F000, 1'b0};
    vecs[4] = '{LF_NAND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hFF0F_FFF0, 1'b0};
    vecs[5] = '{LF_XNOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'h00FF_F00F, 1'b0};
    vecs[6] = '{LF_ANDN,  32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hF000_00F0, 1'b0};
    vecs[7] = '{LF_PASSA, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hF0F0_00FF, 1'b0};
    vecs[8] = '{LF_XOR,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'h0000_0000, 1'b1};

    // Reset held two cycles while issue requests are presented.
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) set_in(sels[i], 1'b1, LF_OR, 32'hFFFF_FFFF, 32'h1, 4'hF, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle(sels[i], 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(sels[i]);
      chk($sformatf("rst_out_valid_s%0d", sels[i]), 32'(o.ov), 32'd0);
      chk($sformatf("rst_out_data_s%0d", sels[i]), o.od, 32'd0);
      chk($sformatf("rst_out_tag_s%0d", sels[i]), 32'(o.ot), 32'd0);
      chk($sformatf("rst_out_zero_s%0d", sels[i]), 32'(o.oz), 32'd1);
      chk($sformatf("rst_occupancy_s%0d", sels[i]), 32'(o.occ), 32'd0);
      chk($sformatf("rst_in_ready_s%0d", sels[i]), 32'(o.ir), 32'd1);
    end

    // All eight ops back-to-back; each result appears two cycles after issue.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) set_in(2, 1'b1, vecs[c].op, vecs[c].a, vecs[c].b, vecs[c].tag, 1'b1);
      else idle(2, 1'b1);
      #1;
      o = get_obs(2);
      if (c < 8) chk($sformatf("ops_in_ready_c%0d", c), 32'(o.ir), 32'd1);
      if (c >= 2) begin
        chk($sformatf("ops_valid_op%0d", c - 2), 32'(o.ov), 32'd1);
        chk($sformatf("ops_data_op%0d", c - 2), o.od, vecs[c-2].exp);
        chk($sformatf("ops_tag_op%0d", c - 2), 32'(o.ot), 32'(vecs[c-2].tag));
        chk($sformatf("ops_zero_op%0d", c - 2), 32'(o.oz), 32'(vecs[c-2].zero));
      end else begin
        chk($sformatf("ops_early_valid_c%0d", c), 32'(o.ov), 32'd0);
      end
      tick();
    end

    // Backpressure: six ops with the CDB stalled for the first four cycles.
    in_i  = 0;
    out_i = 0;
    for (int c = 0; c < 40 && out_i < 6; c++) begin
      ordy = (c >= 4);
      if (in_i < 6) set_in(2, 1'b1, LF_PASSA, bpa(in_i), ~bpa(in_i), 4'(in_i), ordy);
      else idle(2, ordy);
      #1;
      o = get_obs(2);
      if (c == 2 || c == 3) begin
        chk($sformatf("bp_occupancy_c%0d", c), 32'(o.occ), 32'd2);
        chk($sformatf("bp_in_ready_c%0d", c), 32'(o.ir), 32'd0);
        chk($sformatf("bp_out_valid_c%0d", c), 32'(o.ov), 32'd1);
        chk($sformatf("bp_held_data_c%0d", c), o.od, bpa(0));
        chk($sformatf("bp_held_tag_c%0d", c), 32'(o.ot), 32'd0);
      end
      if (o.ov && ordy) begin
        chk($sformatf("bp_out_data_%0d", out_i), o.od, bpa(out_i));
        chk($sformatf("bp_out_tag_%0d", out_i), 32'(o.ot), 32'(out_i[3:0]));
        out_i++;
      end
      if (o.ir && in_i < 6) in_i++;
      tick();
    end
    chk("bp_delivered", 32'(out_i), 32'd6);

    // Flush with two ops in flight and a third presented on the flush cycle.
    set_in(2, 1'b1, LF_PASSA, 32'h8, 32'h0, 4'h8, 1'b1);
    #1;
    o = get_obs(2);
    chk("fl_in_ready_0", 32'(o.ir), 32'd1);
    tick();
    set_in(2, 1'b1, LF_PASSA, 32'h9, 32'h0, 4'h9, 1'b1);
    #1;
    o = get_obs(2);
    chk("fl_in_ready_1", 32'(o.ir), 32'd1);
    tick();
    flush = 1'b1;
    set_in(2, 1'b1, LF_PASSA, 32'hA, 32'h0, 4'hA, 1'b1);
    #1;
    o = get_obs(2);
    chk("fl_out_valid_flush", 32'(o.ov), 32'd0);
    chk("fl_in_ready_flush", 32'(o.ir), 32'd0);
    chk("fl_occupancy_flush", 32'(o.occ), 32'd2);
    tick();
    flush = 1'b0;
    idle(2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      o = get_obs(2);
      if (c == 0) chk("fl_occupancy_after", 32'(o.occ), 32'd0);
      chk($sformatf("fl_no_ghost_c%0d", c), 32'(o.ov), 32'd0);
      tick();
    end

    // Zero result and latency at each depth.
    lat_test(1);
    lat_test(2);
    lat_test(4);

    // Single-stage unit: ready follows the CDB grant when the slot is full.
    set_in(1, 1'b1, LF_AND, 32'h0000_FFFF, 32'h00FF_00FF, 4'h7, 1'b0);
    tick();
    idle(1, 1'b0);
    #1;
    o = get_obs(1);
    chk("s1_full_valid", 32'(o.ov), 32'd1);
    chk("s1_full_data", o.od, 32'h0000_00FF);
    chk("s1_full_in_ready", 32'(o.ir), 32'd0);
    chk("s1_full_occupancy", 32'(o.occ), 32'd1);
    idle(1, 1'b1);
    #1;
    o = get_obs(1);
    chk("s1_grant_in_ready", 32'(o.ir), 32'd1);
    tick();
    #1;
    o = get_obs(1);
    chk("s1_drained", 32'(o.occ), 32'd0);

    // Random traffic against a queue scoreboard.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      logic        f, iv, rr;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [3:0]  tag;
      exp_t        e;
      f   = ($urandom_range(0, 39) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      rr  = ($urandom_range(0, 9) < 7);
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
      tag = 4'($urandom_range(0, 15));
      flush = f;
      set_in(2, iv, op, a, b, tag, rr);
      #1;
      o = get_obs(2);
      chk("rnd_occupancy", 32'(o.occ), 32'(sb.size()));
      chk("rnd_in_ready", 32'(o.ir), 32'(!f && (sb.size() < 2 || rr)));
      if (f) begin
        chk("rnd_flush_out_valid", 32'(o.ov), 32'd0);
        sb.delete();
      end else begin
        if (sb.size() == 0) begin
          chk("rnd_out_valid_empty", 32'(o.ov), 32'd0);
        end else if (o.ov && rr) begin
          e = sb.pop_front();
          chk("rnd_out_data", o.od, e.data);
          chk("rnd_out_tag", 32'(o.ot), 32'(e.tag));
          chk("rnd_out_zero", 32'(o.oz), 32'(e.zero));
        end
        if (o.ir && iv) begin
          e.data = ref_op(op, a, b);
          e.tag  = tag;
          e.zero = (e.data == 32'd0);
          sb.push_back(e);
        end
      end
      tick();
    end
    flush = 1'b0;
    idle(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
